// File: rtl/mem_ctrl.sv
// Data-side memory responder: serialises one byte/half/word load or store onto a
// byte-wide RAM/IO port and returns a registered one-cycle completion pulse.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        cache_valid,
    input  logic        cache_wr,
    input  logic [2:0]  cache_size,
    input  logic [31:0] cache_addr,
    input  logic [31:0] cache_value,
    output logic        cache_ready,
    output logic [31:0] cache_res,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     value_q, value_d;
    logic [31:0]     res_q, res_d;
    logic [2:0]      size_q, size_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0][7:0] rbuf_q, rbuf_d;
    logic            iss_vld_q, iss_vld_d;
    logic [1:0]      iss_idx_q, iss_idx_d;
    logic            ready_q, ready_d;
    logic            rdy_prev_q;

    logic [2:0]      nbytes;
    logic            io_stall;
    logic            sgn;
    logic [31:0]     val_sh;
    logic [3:0][7:0] bytes_w;

    always_comb begin
        case (size_q[1:0])
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign io_stall    = (addr_q[17:16] == 2'b11) && io_buffer_full;
    assign sgn         = ~size_q[2];
    assign val_sh      = value_q >> {idx_q[1:0], 3'b000};
    assign cache_ready = ready_q;
    assign cache_res   = res_q;

    always_comb begin
        mem_a    = '0;
        mem_dout = '0;
        mem_wr   = 1'b0;
        case (state_q)
            WRITE: begin
                mem_a    = addr_q + {29'd0, idx_q};
                mem_dout = val_sh[7:0];
                mem_wr   = rdy_in && !io_stall;
            end
            READ:    mem_a = addr_q + {29'd0, idx_q};
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        value_d   = value_q;
        size_d    = size_q;
        idx_d     = idx_q;
        rbuf_d    = rbuf_q;
        iss_vld_d = 1'b0;
        iss_idx_d = iss_idx_q;
        ready_d   = 1'b0;
        res_d     = '0;
        // mem_din belongs to whatever index was issued in the previous cycle
        bytes_w   = rbuf_q;
        if (iss_vld_q) bytes_w[iss_idx_q] = mem_din;
        case (state_q)
            IDLE: if (cache_valid) begin
                addr_d  = cache_addr;
                value_d = cache_value;
                size_d  = cache_size;
                idx_d   = '0;
                state_d = cache_wr ? WRITE : READ;
            end
            WRITE: if (!io_stall) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == nbytes - 3'd1) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end
            end
            READ: if (!rdy_prev_q) begin
                // first edge after a pause: the RAM pipe is stale, start over
                idx_d = '0;
            end else begin
                rbuf_d    = bytes_w;
                iss_vld_d = idx_q < nbytes;
                iss_idx_d = idx_q[1:0];
                if (idx_q < nbytes) idx_d = idx_q + 3'd1;
                if (iss_vld_q && ({1'b0, iss_idx_q} == nbytes - 3'd1)) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    case (size_q[1:0])
                        2'd0:    res_d = {{24{bytes_w[0][7] & sgn}}, bytes_w[0]};
                        2'd1:    res_d = {{16{bytes_w[1][7] & sgn}}, bytes_w[1], bytes_w[0]};
                        default: res_d = bytes_w;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            value_q    <= '0;
            size_q     <= '0;
            idx_q      <= '0;
            rbuf_q     <= '0;
            iss_vld_q  <= 1'b0;
            iss_idx_q  <= '0;
            ready_q    <= 1'b0;
            res_q      <= '0;
            rdy_prev_q <= 1'b0;
        end else begin
            rdy_prev_q <= rdy_in;
            if (rdy_in) begin
                state_q   <= state_d;
                addr_q    <= addr_d;
                value_q   <= value_d;
                size_q    <= size_d;
                idx_q     <= idx_d;
                rbuf_q    <= rbuf_d;
                iss_vld_q <= iss_vld_d;
                iss_idx_q <= iss_idx_d;
                ready_q   <= ready_d;
                res_q     <= res_d;
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-RAM model, write log and a result/latency scoreboard,
// a vector table for plain accesses plus sequences for stall, pause and reset.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        cache_valid = 1'b0;
    logic        cache_wr = 1'b0;
    logic [2:0]  cache_size = '0;
    logic [31:0] cache_addr = '0;
    logic [31:0] cache_value = '0;
    logic        cache_ready;
    logic [31:0] cache_res;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full = 1'b0;

    mem_ctrl dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .cache_valid(cache_valid), .cache_wr(cache_wr), .cache_size(cache_size),
        .cache_addr(cache_addr), .cache_value(cache_value),
        .cache_ready(cache_ready), .cache_res(cache_res),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] value;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  ram [logic [31:0]];
    logic [39:0] wlog [$];
    exp_t        sbq [$];
    exp_t        mon_e;
    vec_t        vt [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM returns data one cycle after the address is presented
    always @(posedge clk) begin
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    always @(negedge clk) begin
        if (mem_wr) wlog.push_back({mem_a, mem_dout});
        if (cache_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 res=%h want no ready", cache_res);
            end else begin
                mon_e = sbq.pop_front();
                chk("res", cache_res, mon_e.res);
                chk("ready_cycle", cyc, mon_e.cyc);
            end
        end
    end

    function automatic int nb(input logic [2:0] s);
        return (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
    endfunction

    task automatic wait_ready();
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cache_ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got no ready within 40 cycles want ready");
        end
    endtask

    task automatic check_writes(input logic [31:0] a, input logic [31:0] v, input int n);
        logic [31:0] vs;
        chk("wr_count", wlog.size(), n);
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            vs = v >> (8 * k);
            chk("wr_addr", wlog[k][39:8], a + k);
            chk("wr_data", {24'd0, wlog[k][7:0]}, {24'd0, vs[7:0]});
        end
        wlog.delete();
    endtask

    task automatic drive(input bit wr, input logic [2:0] s, input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        cache_valid = 1'b1;
        cache_wr    = wr;
        cache_size  = s;
        cache_addr  = a;
        cache_value = v;
    endtask

    task automatic run_vec(input vec_t t);
        drive(t.wr, t.size, t.addr, t.value);
        @(posedge clk);
        #1 sbq.push_back('{t.res, cyc + t.lat});
        wait_ready();
        cache_valid = 1'b0;
        check_writes(t.addr, t.value, t.wr ? nb(t.size) : 0);
    endtask

    initial begin
        int c0;
        ram[32'h100] = 8'h80;
        ram[32'h104] = 8'h9C;
        ram[32'h202] = 8'h00; ram[32'h203] = 8'hF0;
        ram[32'h3FE] = 8'h11; ram[32'h3FF] = 8'h22;
        ram[32'h400] = 8'h33; ram[32'h401] = 8'h44;

        //          wr  size    addr          value         res           lat
        vt[0]  = '{1'b0, 3'd0, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 2};
        vt[1]  = '{1'b0, 3'd4, 32'h0000_0100, 32'h0,        32'h0000_0080, 2};
        vt[2]  = '{1'b0, 3'd1, 32'h0000_0202, 32'h0,        32'hFFFF_F000, 3};
        vt[3]  = '{1'b0, 3'd5, 32'h0000_0202, 32'h0,        32'h0000_F000, 3};
        vt[4]  = '{1'b0, 3'd2, 32'h0000_03FE, 32'h0,        32'h4433_2211, 5};
        vt[5]  = '{1'b0, 3'd6, 32'h0000_03FE, 32'h0,        32'h4433_2211, 5};
        vt[6]  = '{1'b1, 3'd2, 32'h0000_0100, 32'h1234_5678, 32'h0,        4};
        vt[7]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,        32'h1234_5678, 5};
        vt[8]  = '{1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h0000_0056, 2};
        vt[9]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'hCAFE_BEEF, 32'h0,        2};
        vt[10] = '{1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_BEEF, 3};
        vt[11] = '{1'b1, 3'd0, 32'h0000_0050, 32'hDEAD_BEA5, 32'h0,        1};
        vt[12] = '{1'b0, 3'd4, 32'h0000_0050, 32'h0,        32'h0000_00A5, 2};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, cache_ready}, 32'd0);
        chk("rst_res", cache_res, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vt[i]);

        // request held through DONE with a new address must wait one more edge
        drive(1'b0, 3'd0, 32'h100, 32'h0);
        @(posedge clk);
        #1 sbq.push_back('{32'h0000_0078, cyc + 2});
        wait_ready();
        cache_addr = 32'h104;
        sbq.push_back('{32'hFFFF_FF9C, cyc + 4});
        wait_ready();
        cache_valid = 1'b0;
        check_writes(32'h0, 32'h0, 0);

        // IO write held off by a full UART buffer
        io_full = 1'b1;
        drive(1'b1, 3'd0, 32'h0003_0000, 32'h0000_0041);
        @(posedge clk);
        #1 sbq.push_back('{32'h0, cyc + 4});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
            @(posedge clk);
            #1;
        end
        io_full = 1'b0;
        @(negedge clk);
        chk("io_wr", {31'd0, mem_wr}, 32'd1);
        chk("io_addr", mem_a, 32'h0003_0000);
        chk("io_dout", {24'd0, mem_dout}, 32'h41);
        wait_ready();
        cache_valid = 1'b0;
        check_writes(32'h0003_0000, 32'h41, 1);

        // store paused for one cycle resumes at the held byte
        drive(1'b1, 3'd2, 32'h500, 32'hA1B2_C3D4);
        @(posedge clk);
        #1 sbq.push_back('{32'h0, cyc + 5});
        @(posedge clk);
        #1 rdy = 1'b0;
        #1 chk("pause_wr", {31'd0, mem_wr}, 32'd0);
        @(posedge clk);
        #1 rdy = 1'b1;
        wait_ready();
        cache_valid = 1'b0;
        check_writes(32'h500, 32'hA1B2_C3D4, 4);

        // word load paused in cycles 2..3 restarts from byte 0
        drive(1'b0, 3'd2, 32'h3FE, 32'h0);
        @(posedge clk);
        #1 c0 = cyc;
        sbq.push_back('{32'h4433_2211, c0 + 10});
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
        wait_ready();
        cache_valid = 1'b0;
        check_writes(32'h0, 32'h0, 0);

        // reset in the middle of a word load
        drive(1'b0, 3'd2, 32'h3FE, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        cache_valid = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, cache_ready}, 32'd0);
        chk("midrst_res", cache_res, 32'd0);
        chk("midrst_mem_a", mem_a, 32'd0);
        chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("midrst_mem_dout", {24'd0, mem_dout}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_vec(vt[4]);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Data-side memory responder: the slave end of the load/store buffer's `cache_*` request interface. It accepts one byte/half/word load or store at a time and serialises it onto the byte-wide RAM/IO port. For loads it reassembles little-endian bytes and sign- or zero-extends the result. It returns a one-cycle `cache_ready` pulse carrying the result.

## Interface
- No parameters.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global ready; low pauses the block.
- `cache_valid` in 1: request present; held high until `cache_ready`.
- `cache_wr` in 1: 1 = store, 0 = load.
- `cache_size` in 3: `[1:0]` 0 = byte, 1 = half, 2 = word. `[2]` 1 = unsigned load, 0 = signed; ignored for word accesses and stores.
- `cache_addr` in 32: byte address; no alignment required.
- `cache_value` in 32: store data; the low n bytes are used.
- `cache_ready` out 1: one-cycle completion pulse.
- `cache_res` out 32: load result, valid while `cache_ready`; 0 for stores.
- `mem_din` in 8: RAM read data for the address driven in the previous cycle.
- `mem_dout` out 8: RAM write data.
- `mem_a` out 32: RAM/IO byte address.
- `mem_wr` out 1: 1 = write `mem_dout` to `mem_a` this cycle.
- `io_buffer_full` in 1: UART buffer full; stalls IO writes.

## Operation
- State machine states:
  - IDLE: at a rising edge with `cache_valid`=1 and `rdy_in`=1, latch addr, size, wr and value. Clear byte index i. Go to READ or WRITE.
  - WRITE: in cycle k, drive `mem_a`=addr+k, `mem_dout`=value[8k+7:8k], `mem_wr`=1.
    - i advances at each `rdy_in`-high edge.
    - After byte n-1, go to DONE.
    - IO stall: if addr[17:16]==2'b11 and `io_buffer_full`=1, drive `mem_wr`=0 and hold i.
  - READ: issue `mem_a`=addr+i for i = 0..n-1, one byte per cycle, with `mem_wr`=0.
    - At each edge, capture `mem_din` into byte slot i-1 when the previous cycle issued index i-1.
    - After slot n-1 is captured, form the result and go to DONE.
  - DONE: `cache_ready`=1 for exactly one cycle, then go to IDLE.
    - `cache_valid` is ignored in DONE, because the requester still shows the completed request during this cycle.
    - The next request is accepted at the following edge at the earliest.
- Result formation:
  - byte: {24{b0[7] & signed}, b0}.
  - half: {16{b1[7] & signed}, b1, b0}.
  - word: {b3, b2, b1, b0}.
- Address arithmetic is 32-bit and wraps at 0xFFFFFFFF → 0; there is no misalignment fault.
- `mem_a`/`mem_dout` are don't-care when not writing or issuing; drive 0 in IDLE and DONE.
- `rdy_in` low:
  - No register updates; `mem_wr` is forced to 0.
  - A READ in progress restarts from byte 0 at the first `rdy_in`-high edge after the pause, detected by a registered copy of `rdy_in`. Bytes already captured are discarded.
  - A WRITE resumes at the held byte.
- Reset (`rst_in` low, any time, including mid-transfer): state returns to IDLE immediately. `cache_ready`=0, `cache_res`=0, `mem_wr`=0, `mem_a`=0, `mem_dout`=0, i=0.
  - A partially written word stays partially written.
  - After release, the first acceptance can happen at the first edge.

## Timing
- Acceptance edge E0; cycle k is the cycle after edge Ek.
- Store of n bytes: writes in cycles 0..n-1, `cache_ready` in cycle n. Word = 4, byte = 1, plus IO-stall cycles.
- Load of n bytes: addresses in cycles 0..n-1, captures at E2..E(n+1), `cache_ready` in cycle n+1. Byte = 2, half = 3, word = 5.
- Back-to-back throughput: one request per (latency+2) cycles, including the DONE ignore cycle.
- `cache_ready`/`cache_res` are registered; `mem_wr` is combinational from state, `rdy_in` and `io_buffer_full`.

## Test plan
- Store word 0x12345678 to 0x100 → `mem_wr`=1 in cycles 0..3 at 0x100..0x103 with dout 78,56,34,12. `cache_ready` in cycle 4, res 0.
- RAM[0x100]=0x80: LB → res 0xFFFFFF80 in cycle 2; LBU → 0x00000080. RAM[0x202..0x203]=00,F0: LH at 0x202 → 0xFFFFF000; LHU → 0x0000F000.
- Word load at 0x3FE with bytes 11,22,33,44 → res 0x44332211 in cycle 5; addresses 0x3FE..0x401 (unaligned crossing).
- `cache_valid` held high through the DONE cycle while addr changes 0x100→0x104 → no acceptance in DONE. The second request, at 0x104, is accepted at the next edge.
- Store byte 0x41 to 0x30000 with `io_buffer_full`=1 for 3 cycles → `mem_wr`=0 for those 3 cycles, then one write of 0x41. `cache_ready` the following cycle.
- Pause and reset during a word load:
  - Word load with `rdy_in` low for 2 cycles starting at cycle 2 → reissues from byte 0. Correct result, `cache_ready` 5 cycles after the resume edge.
  - Separately, `rst_in` low in cycle 2 → all outputs 0 immediately and no `cache_ready`. A new request after release completes normally.
